// File: rtl/scan_pkg.sv
// Shared state encoding and mode codes for the boundary-scan master.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SHIFT  = 3'd2,
    UPDATE = 3'd3,
    FIN    = 3'd4
  } scan_state_e;

  localparam logic [1:0] MODE_EXTEST = 2'b01;
  localparam logic [1:0] MODE_INTEST = 2'b10;

  function automatic logic mode_legal(input logic [1:0] m);
    return (m == MODE_EXTEST) || (m == MODE_INTEST);
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load, serial-in/serial-out register; shifts right, ser_in enters at MSB.
module scan_shift_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // load has priority over shift
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_val;
    end else if (shift) begin
      data_d = {ser_in, data_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/scan_chain_master.sv
// Host-side boundary-scan driver: shifts a pattern out on tdi while capturing
// tdo into a parallel response word, then strobes update.
module scan_chain_master
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 4
) (
  input  logic                 tck,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           req_mode,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern,
  output logic                 tdi,
  input  logic                 tdo,
  output logic                 extest,
  output logic                 intest,
  output logic                 shift_en,
  output logic                 update,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CHAIN_LEN-1:0] capture
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

  scan_state_e          state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 extest_q, extest_d;
  logic                 intest_q, intest_d;
  logic                 shift_en_q, shift_en_d;
  logic                 update_q, update_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 pat_load, pat_shift;
  logic [CHAIN_LEN-1:0] pat_load_val, pat_q;
  logic                 cap_load, cap_shift;
  logic                 abort_hit, strobe_on;
  logic                 pat_unused;

  // tdi is the pattern register's LSB, so it is a flop output; clearing the
  // register on abort keeps tdi low outside SETUP/SHIFT.
  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_pat (
    .clk      (tck),
    .rst      (rst),
    .load     (pat_load),
    .load_val (pat_load_val),
    .shift    (pat_shift),
    .ser_in   (1'b0),
    .q        (pat_q)
  );

  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_cap (
    .clk      (tck),
    .rst      (rst),
    .load     (cap_load),
    .load_val ('0),
    .shift    (cap_shift),
    .ser_in   (tdo),
    .q        (capture)
  );

  assign tdi        = pat_q[0];
  assign pat_unused = ^pat_q[CHAIN_LEN-1:1];

  // next state, shift-register controls and registered-output targets
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    pat_load     = 1'b0;
    pat_shift    = 1'b0;
    pat_load_val = pattern;
    cap_load     = 1'b0;
    cap_shift    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (mode_legal(req_mode)) begin
            state_d  = SETUP;
            mode_d   = req_mode;
            cnt_d    = CNT_W'(CHAIN_LEN);
            err_d    = 1'b0;
            pat_load = 1'b1;
            cap_load = 1'b1;
          end else begin
            state_d = FIN;
            err_d   = 1'b1;
          end
        end
      end
      SETUP: state_d = SHIFT;
      SHIFT: begin
        pat_shift = 1'b1;
        cap_shift = 1'b1;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = UPDATE;
        end
      end
      UPDATE:  state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    abort_hit = abort && ((state_q == SETUP) || (state_q == SHIFT));
    if (abort_hit) begin
      state_d      = FIN;
      err_d        = 1'b1;
      cnt_d        = '0;
      pat_load     = 1'b1;
      pat_load_val = '0;
    end

    strobe_on  = (state_d == SETUP) || (state_d == SHIFT) || (state_d == UPDATE);
    extest_d   = strobe_on && (mode_d == MODE_EXTEST);
    intest_d   = strobe_on && (mode_d == MODE_INTEST);
    shift_en_d = (state_d == SHIFT);
    update_d   = (state_d == UPDATE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FIN);
  end

  // FSM state and registered outputs
  always_ff @(posedge tck) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      cnt_q      <= '0;
      extest_q   <= 1'b0;
      intest_q   <= 1'b0;
      shift_en_q <= 1'b0;
      update_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      extest_q   <= extest_d;
      intest_q   <= intest_d;
      shift_en_q <= shift_en_d;
      update_q   <= update_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign extest   = extest_q;
  assign intest   = intest_q;
  assign shift_en = shift_en_q;
  assign update   = update_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_scan_chain_master.sv
// Bench for scan_chain_master: loopback chain model plus a done-time scoreboard.
module tb_scan_chain_master;

  localparam int unsigned N = 4;

  logic         tck = 1'b0;
  logic         rst, start, abort;
  logic [1:0]   req_mode;
  logic [N-1:0] pattern;
  logic         tdi, tdo, extest, intest, shift_en, update, busy, done, err;
  logic [N-1:0] capture;
  logic [N-1:0] chain = '0;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic         e;
    logic [N-1:0] cap;
    bit           chk_cap;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] tr [0:23];
  int         done_k;

  always #5 tck = ~tck;

  scan_chain_master #(.CHAIN_LEN(N)) dut (
    .tck      (tck),
    .rst      (rst),
    .start    (start),
    .req_mode (req_mode),
    .abort    (abort),
    .pattern  (pattern),
    .tdi      (tdi),
    .tdo      (tdo),
    .extest   (extest),
    .intest   (intest),
    .shift_en (shift_en),
    .update   (update),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .capture  (capture)
  );

  // loopback chain: N cells that only move while shift_en is high
  assign tdo = chain[N-1];
  always @(posedge tck) if (shift_en) chain <= {chain[N-2:0], tdi};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] rev(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int unsigned i = 0; i < N; i++) r[i] = v[N-1-i];
    return r;
  endfunction

  // scoreboard: every done pulse must match a queued expectation
  always @(negedge tck) begin
    exp_t x;
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        x = sb.pop_front();
        chk("sb_err", {31'd0, err}, {31'd0, x.e});
        if (x.chk_cap) chk("sb_capture", {28'd0, capture}, {28'd0, x.cap});
      end
    end
  end

  // k = 1 is the cycle after the accepting edge; tr[k] = {busy,done,err,shift_en,update,extest,intest,tdi}
  task automatic run_scan(input logic [N-1:0] pat, input logic [1:0] m,
                          input int abort_k, input int restart_k, input int rst_k,
                          input bit push, input bit exp_e, input bit chk_cap);
    exp_t x;
    done_k = -1;
    for (int i = 0; i < 24; i++) tr[i] = '0;
    @(negedge tck);
    pattern  = pat;
    req_mode = m;
    start    = 1'b1;
    if (push) begin
      x.e       = exp_e;
      x.cap     = rev(chain);
      x.chk_cap = chk_cap;
      sb.push_back(x);
    end
    for (int k = 1; k < 24; k++) begin
      @(negedge tck);
      tr[k]   = {busy, done, err, shift_en, update, extest, intest, tdi};
      start   = 1'b0;
      abort   = 1'b0;
      rst     = 1'b0;
      pattern = ~pat;
      if (k == abort_k)   abort = 1'b1;
      if (k == restart_k) start = 1'b1;
      if (k == rst_k)     rst   = 1'b1;
      if (done === 1'b1 && done_k < 0) done_k = k;
      if (done_k >= 0 && k == done_k + 1) break;
      if (rst_k > 0 && k == rst_k + 1) break;
    end
  endtask

  task automatic check_trace(input logic [N-1:0] pat, input logic [1:0] m, input string run);
    logic [7:0] e;
    for (int k = 1; k <= 8; k++) begin
      e    = '0;
      e[7] = (k <= 7);
      e[6] = (k == 7);
      e[4] = (k >= 2 && k <= 5);
      e[3] = (k == 6);
      e[2] = (m == 2'b01) && (k <= 6);
      e[1] = (m == 2'b10) && (k <= 6);
      if (k == 1)      e[0] = pat[0];
      else if (k <= 5) e[0] = pat[k-2];
      chk($sformatf("%s_trace_k%0d", run, k), {24'd0, tr[k] & 8'hDF}, {24'd0, e});
    end
  endtask

  initial begin
    logic upd_seen;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    req_mode = 2'b00;
    pattern  = '0;
    repeat (2) @(negedge tck);
    chk("reset_outs", {24'd0, busy, done, err, shift_en, update, extest, intest, tdi}, 32'd0);
    chk("reset_capture", {28'd0, capture}, 32'd0);
    rst = 1'b0;

    // EXTEST loopback, empty chain
    run_scan(4'b1011, 2'b01, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    chk("r1_done_k", done_k, 7);
    check_trace(4'b1011, 2'b01, "r1");

    // second loopback run returns the first pattern
    run_scan(4'b0110, 2'b01, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    chk("r2_done_k", done_k, 7);
    chk("r2_capture_hold", {28'd0, capture}, 32'hB);
    check_trace(4'b0110, 2'b01, "r2");

    // INTEST
    run_scan(4'b1100, 2'b10, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    chk("r3_done_k", done_k, 7);
    check_trace(4'b1100, 2'b10, "r3");

    // illegal modes
    for (int i = 0; i < 2; i++) begin
      run_scan(4'b1111, (i == 0) ? 2'b11 : 2'b00, 0, 0, 0, 1'b1, 1'b1, 1'b0);
      chk("ill_done_k", done_k, 1);
      chk("ill_k1", {24'd0, tr[1] & 8'hDE}, 32'hC0);
      chk("ill_k2_busy", {31'd0, tr[2][7]}, 32'd0);
      chk("ill_k2_strobes", {24'd0, tr[2] & 8'h1E}, 32'd0);
    end

    // abort during the 2nd SHIFT cycle
    run_scan(4'b1001, 2'b01, 3, 0, 0, 1'b1, 1'b1, 1'b0);
    chk("abort_done_k", done_k, 4);
    upd_seen = 1'b0;
    for (int k = 1; k <= 5; k++) upd_seen |= tr[k][3];
    chk("abort_update", {31'd0, upd_seen}, 32'd0);
    chk("abort_fin_strobes", {30'd0, tr[4][2:1]}, 32'd0);
    chk("abort_busy_fall", {31'd0, tr[5][7]}, 32'd0);

    // reset in the middle of SHIFT
    run_scan(4'b0101, 2'b10, 0, 0, 3, 1'b0, 1'b0, 1'b0);
    chk("rst_outs", {24'd0, tr[4]}, 32'd0);
    chk("rst_capture", {28'd0, capture}, 32'd0);

    // clean scan after reset
    run_scan(4'b0011, 2'b10, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    chk("r7_done_k", done_k, 7);
    check_trace(4'b0011, 2'b10, "r7");

    // start re-pulsed during SHIFT is ignored
    run_scan(4'b1110, 2'b01, 0, 3, 0, 1'b1, 1'b0, 1'b1);
    chk("r8_done_k", done_k, 7);
    check_trace(4'b1110, 2'b01, "r8");

    // start together with abort in IDLE is ignored
    @(negedge tck);
    start    = 1'b1;
    abort    = 1'b1;
    req_mode = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      @(negedge tck);
      start = 1'b0;
      abort = 1'b0;
      chk($sformatf("startabort_busy_k%0d", k), {31'd0, busy}, 32'd0);
    end

    repeat (5) @(negedge tck);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
